// File: rtl/wfg_drive_pat_core_if.sv
// Sample stream link between the upstream sample source and the pattern driver.
// The source (master) offers tdata/tvalid; the driver (slave) returns tready.
interface wfg_drive_pat_core_if #(
    parameter int unsigned CHANNELS = 16
);
    logic [CHANNELS-1:0] tdata;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/wfg_drive_pat_core.sv
// Pattern driver: pulls one sample per core sync and drives per-channel pattern outputs.
// Optional return-to-zero forcing is enabled with WFG_DRIVE_PAT_RTZ_EN (adds rtz_cnt_i).
module wfg_drive_pat_core #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned IDXW     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wfg_pat_sync_i,
    input  logic                    wfg_pat_subcycle_i,
    input  logic                    wfg_pat_start_i,
    input  logic [7:0]              wfg_pat_subcycle_cnt_i,
    input  logic                    active_i,
    input  logic                    ctrl_en_i,
    input  logic [2*CHANNELS-1:0]   patsel_i,
    input  logic [IDXW-1:0]         begin_i,
    input  logic [IDXW-1:0]         end_i,
`ifdef WFG_DRIVE_PAT_RTZ_EN
    input  logic [7:0]              rtz_cnt_i,
`endif
    wfg_drive_pat_core_if.slave     axis,
    output logic [CHANNELS-1:0]     pat_o,
    output logic [IDXW-1:0]         index_o,
    output logic                    wrap_o,
    output logic                    underflow_o,
    output logic                    busy_o
);
    typedef enum logic [1:0] {IDLE, WAIT_START, RUN} state_t;

    state_t              state;
    logic [CHANNELS-1:0] smp_q;
    logic                first_q;
    logic                rtz_q;

    logic                abort;
    logic                sample_ev;
    logic                rtz_hit;
    logic [CHANNELS-1:0] smp_nxt;
    logic [IDXW-1:0]     eff_end;

    // Per-channel mode: 00 low, 01 high, 10 sample bit, 11 inverted sample bit.
    function automatic logic [CHANNELS-1:0] pat_of(input logic [2*CHANNELS-1:0] sel,
                                                   input logic [CHANNELS-1:0]   smp);
        logic [CHANNELS-1:0] r;
        r = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            case (sel[2*n +: 2])
                2'b00:   r[n] = 1'b0;
                2'b01:   r[n] = 1'b1;
                2'b10:   r[n] = smp[n];
                default: r[n] = ~smp[n];
            endcase
        end
        return r;
    endfunction

    assign abort     = (state != IDLE) && (!ctrl_en_i || !active_i);
    assign sample_ev = wfg_pat_sync_i && ctrl_en_i && active_i &&
                       ((state == RUN) || ((state == WAIT_START) && wfg_pat_start_i));
    assign axis.tready = sample_ev;
    assign smp_nxt   = axis.tvalid ? axis.tdata : smp_q;
    assign eff_end   = (end_i < begin_i) ? begin_i : end_i;

`ifdef WFG_DRIVE_PAT_RTZ_EN
    assign rtz_hit = (state == RUN) && wfg_pat_subcycle_i &&
                     (wfg_pat_subcycle_cnt_i == rtz_cnt_i) && (rtz_cnt_i != 8'd0);
`else
    logic unused_subcycle;
    assign unused_subcycle = ^{wfg_pat_subcycle_i, wfg_pat_subcycle_cnt_i};
    assign rtz_hit = 1'b0;
`endif

    // Control FSM, sample capture, index sequencing and pattern output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            smp_q       <= '0;
            first_q     <= 1'b1;
            rtz_q       <= 1'b0;
            pat_o       <= '0;
            index_o     <= '0;
            wrap_o      <= 1'b0;
            underflow_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            wrap_o <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                smp_q   <= '0;
                first_q <= 1'b1;
                rtz_q   <= 1'b0;
                pat_o   <= '0;
                index_o <= '0;
                busy_o  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ctrl_en_i) begin
                            state       <= WAIT_START;
                            underflow_o <= 1'b0;
                        end
                    end
                    WAIT_START: begin
                        if (wfg_pat_start_i) begin
                            state  <= RUN;
                            busy_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                if (sample_ev) begin
                    smp_q   <= smp_nxt;
                    pat_o   <= pat_of(patsel_i, smp_nxt);
                    first_q <= 1'b0;
                    rtz_q   <= 1'b0;
                    if (!axis.tvalid) underflow_o <= 1'b1;
                    if (first_q) begin
                        index_o <= begin_i;
                    end else if (index_o >= eff_end) begin
                        index_o <= begin_i;
                        wrap_o  <= 1'b1;
                    end else begin
                        index_o <= index_o + IDXW'(1);
                    end
                end else if ((state == RUN) && !first_q) begin
                    // Between samples, mode changes apply immediately unless RTZ holds low.
                    if (rtz_hit) begin
                        pat_o <= '0;
                        rtz_q <= 1'b1;
                    end else if (!rtz_q) begin
                        pat_o <= pat_of(patsel_i, smp_q);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wfg_drive_pat_core.sv
// Randomized and directed bench for wfg_drive_pat_core against a behavioural model.
// Define WFG_DRIVE_PAT_RTZ_EN on both RTL and bench to cover the return-to-zero option.
module tb_wfg_drive_pat_core;
    localparam int unsigned CH = 16;
    localparam int unsigned IW = 8;
    localparam int unsigned PW = 2 * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync, subc, start, active, en;
    logic [7:0]    scnt;
    logic [PW-1:0] patsel;
    logic [IW-1:0] bgn, endi;
    logic [CH-1:0] pat;
    logic [IW-1:0] idx;
    logic          wrap, uf, busy;
`ifdef WFG_DRIVE_PAT_RTZ_EN
    logic [7:0]    rtz_cnt;
`endif

    wfg_drive_pat_core_if #(.CHANNELS(CH)) axis ();

    always #5 clk = ~clk;

    wfg_drive_pat_core #(.CHANNELS(CH), .IDXW(IW)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .wfg_pat_sync_i         (sync),
        .wfg_pat_subcycle_i     (subc),
        .wfg_pat_start_i        (start),
        .wfg_pat_subcycle_cnt_i (scnt),
        .active_i               (active),
        .ctrl_en_i              (en),
        .patsel_i               (patsel),
        .begin_i                (bgn),
        .end_i                  (endi),
`ifdef WFG_DRIVE_PAT_RTZ_EN
        .rtz_cnt_i              (rtz_cnt),
`endif
        .axis                   (axis.slave),
        .pat_o                  (pat),
        .index_o                (idx),
        .wrap_o                 (wrap),
        .underflow_o            (uf),
        .busy_o                 (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 waiting for start, 2 running.
    int            m_mode;
    logic [CH-1:0] m_smp, m_pat;
    logic [IW-1:0] m_idx;
    bit            m_have, m_uf, m_wrap, m_rtz;

    function automatic logic [CH-1:0] expect_pat(input logic [PW-1:0] sel, input logic [CH-1:0] smp);
        logic [CH-1:0] r;
        logic [1:0]    m;
        for (int n = 0; n < CH; n++) begin
            m = sel[2*n +: 2];
            if (m == 2'd0)      r[n] = 1'b0;
            else if (m == 2'd1) r[n] = 1'b1;
            else if (m == 2'd2) r[n] = smp[n];
            else                r[n] = !smp[n];
        end
        return r;
    endfunction

    function automatic bit model_ev();
        return sync && en && active && (m_mode == 2 || (m_mode == 1 && start));
    endfunction

    function automatic bit model_rtz();
`ifdef WFG_DRIVE_PAT_RTZ_EN
        return subc && rtz_cnt != 8'd0 && scnt == rtz_cnt;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_smp = '0; m_pat = '0; m_idx = '0;
        m_have = 0; m_uf = 0; m_wrap = 0; m_rtz = 0;
    endtask

    task automatic model_clock();
        bit            ev;
        int            old_mode;
        logic [IW-1:0] top;
        ev       = model_ev();
        old_mode = m_mode;
        top      = (bgn > endi) ? bgn : endi;
        m_wrap   = 0;
        if (old_mode != 0 && (!en || !active)) begin
            m_mode = 0; m_smp = '0; m_pat = '0; m_idx = '0; m_have = 0; m_rtz = 0;
        end else if (old_mode == 0) begin
            if (en) begin m_mode = 1; m_uf = 0; end
        end else begin
            if (old_mode == 1 && start) m_mode = 2;
            if (ev) begin
                if (axis.tvalid) m_smp = axis.tdata;
                else             m_uf = 1;
                if (!m_have)          m_idx = bgn;
                else if (m_idx >= top) begin m_idx = bgn; m_wrap = 1; end
                else                  m_idx = m_idx + IW'(1);
                m_have = 1;
                m_rtz  = 0;
                m_pat  = expect_pat(patsel, m_smp);
            end else if (old_mode == 2 && m_have) begin
                if (model_rtz())  begin m_pat = '0; m_rtz = 1; end
                else if (!m_rtz)  m_pat = expect_pat(patsel, m_smp);
            end
        end
    endtask

    // One clock: check handshake before the edge, advance model, check registers after.
    task automatic tick();
        #1;
        check_eq("tready", 32'(axis.tready), 32'(model_ev()));
        model_clock();
        @(posedge clk);
        #2;
        check_eq("pat", 32'(pat), 32'(m_pat));
        check_eq("index", 32'(idx), 32'(m_idx));
        check_eq("wrap", 32'(wrap), 32'(m_wrap));
        check_eq("underflow", 32'(uf), 32'(m_uf));
        check_eq("busy", 32'(busy), 32'(m_mode == 2));
    endtask

    logic [IW-1:0] exp_idx  [7];
    logic          exp_wrap [7];
    logic [CH-1:0] smp_b;

    initial begin
        exp_idx  = '{8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd2};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        sync = 0; subc = 0; start = 0; active = 0; en = 0; scnt = '0;
        patsel = '0; bgn = '0; endi = '0;
        axis.tdata = '0; axis.tvalid = 0;
`ifdef WFG_DRIVE_PAT_RTZ_EN
        rtz_cnt = 8'd0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check_eq("rst_pat", 32'(pat), 32'd0);
        check_eq("rst_index", 32'(idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_underflow", 32'(uf), 32'd0);

        // Index sequence with wrap, begin=2 end=4.
        en = 1; active = 1; bgn = 8'd2; endi = 8'd4; patsel = {CH{2'b10}};
        axis.tvalid = 1; axis.tdata = 16'h1234;
        tick();
        start = 1; tick(); start = 0;
        for (int k = 0; k < 7; k++) begin
            sync = 1; axis.tdata = CH'($urandom); tick(); sync = 0;
            check_eq("seq_index", 32'(idx), 32'(exp_idx[k]));
            check_eq("seq_wrap", 32'(wrap), 32'(exp_wrap[k]));
            tick(); tick();
        end

        // Mode decode on channels 0..3.
        patsel[7:0] = 8'hE4; axis.tdata = 16'h000C;
        sync = 1; tick(); sync = 0;
        check_eq("mode_decode", 32'(pat[3:0]), 32'(4'b0110));

        // Underflow holds previous sample and is sticky until re-enable.
        en = 0; tick(); en = 1; tick();
        start = 1; tick(); start = 0;
        axis.tdata = 16'hA5C3; sync = 1; tick(); sync = 0; tick();
        smp_b = 16'h3C5A; axis.tdata = smp_b; sync = 1; tick(); sync = 0; tick();
        axis.tvalid = 0; axis.tdata = 16'hFFFF; sync = 1; tick(); sync = 0; axis.tvalid = 1;
        check_eq("uf_hold", 32'(pat), 32'(expect_pat(patsel, smp_b)));
        check_eq("uf_set", 32'(uf), 32'd1);
        repeat (3) tick();
        en = 0; tick();
        check_eq("uf_kept_idle", 32'(uf), 32'd1);
        en = 1; tick();
        check_eq("uf_cleared", 32'(uf), 32'd0);

        // Start and sync together from WAIT_START is the first sample.
        bgn = 8'd5; endi = 8'd9; axis.tdata = 16'h0F0F; start = 1; sync = 1;
        #1 check_eq("start_sync_tready", 32'(axis.tready), 32'd1);
        tick(); start = 0; sync = 0;
        check_eq("start_sync_index", 32'(idx), 32'd5);
        check_eq("start_sync_busy", 32'(busy), 32'd1);

        // Asynchronous reset while running.
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_pat", 32'(pat), 32'd0);
        check_eq("async_rst_index", 32'(idx), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        model_reset();
        en = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;

`ifdef WFG_DRIVE_PAT_RTZ_EN
        // Return-to-zero on matching subcycle, restored by the next sample.
        en = 1; active = 1; patsel = {CH{2'b10}}; rtz_cnt = 8'd3; axis.tvalid = 1;
        tick(); start = 1; tick(); start = 0;
        axis.tdata = 16'hFFFF; sync = 1; tick(); sync = 0;
        check_eq("rtz_pre", 32'(pat), 32'hFFFF);
        subc = 1; scnt = 8'd3; tick(); subc = 0;
        check_eq("rtz_forced", 32'(pat), 32'd0);
        tick();
        check_eq("rtz_held", 32'(pat), 32'd0);
        sync = 1; tick(); sync = 0;
        check_eq("rtz_restored", 32'(pat), 32'hFFFF);
`endif

        // Randomized operation against the model.
        for (int c = 0; c < 1500; c++) begin
            en     = ($urandom_range(0, 99) < 97);
            active = ($urandom_range(0, 99) < 96);
            sync   = ($urandom_range(0, 99) < 30);
            start  = ($urandom_range(0, 99) < 10);
            subc   = ($urandom_range(0, 99) < 40);
            scnt   = 8'($urandom_range(0, 4));
            axis.tvalid = ($urandom_range(0, 99) < 85);
            axis.tdata  = CH'($urandom);
            if ($urandom_range(0, 99) < 5) patsel = PW'($urandom);
            if ($urandom_range(0, 99) < 3) begin
                bgn  = IW'($urandom_range(0, 7));
                endi = IW'($urandom_range(0, 7));
            end
`ifdef WFG_DRIVE_PAT_RTZ_EN
            if ($urandom_range(0, 99) < 3) rtz_cnt = 8'($urandom_range(0, 3));
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
